// File: rtl/overlay_top.sv
// -----------------------------------------------------------------------------
// overlay_top
//   This is a signal-processing overlay that sits between the AD9361 receive
//   interface and the DMA/PS path. It has four independent 16-bit signed sample
//   lanes (I0, Q0, I1, Q1). Each lane is a boxcar moving-average smoother
//   followed by a power-of-two output gain and saturation to 16 bits.
//
//   Pipeline per lane:
//     stage 1 : history shift + running-sum update
//     stage 2 : average, gain, saturate
//   The output strobe appears two cycles after the input strobe. The block
//   has no backpressure.
//
// Parameters
//   LOG2_TAPS  : averaging window = 2^LOG2_TAPS samples (0..6, 0 = pass-through)
//   GAIN_SHIFT : left shift applied after averaging (0..15)
//
// Build option
//   OVERLAY_ROUND_EN : when defined, the average rounds half-up instead of
//                      truncating toward -inf.
//
// Ports
//   i_clk                 single clock
//   i_rst                 synchronous, active-high reset
//   i_{I0,Q0,I1,Q1}_data  signed input samples
//   i_{I0,Q0,I1,Q1}_valid input qualifiers
//   o_{I0,Q0,I1,Q1}_data  signed processed samples (registered, hold between strobes)
//   o_{I0,Q0,I1,Q1}_valid one-cycle output strobes
// -----------------------------------------------------------------------------

module overlay_lane #(
  parameter int LOG2_TAPS  = 2,
  parameter int GAIN_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] in_data,
  input  logic               in_valid,
  output logic signed [15:0] out_data,
  output logic               out_valid
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int SUM_W = 16 + LOG2_TAPS;          // holds TAPS full-scale samples exactly
  localparam int EXT_W = SUM_W + 1;               // headroom for the rounding bias
  localparam int SCL_W = EXT_W + GAIN_SHIFT;      // gain applied at full width

  localparam logic signed [SCL_W-1:0] SAT_MAX = SCL_W'(32767);
  localparam logic signed [SCL_W-1:0] SAT_MIN = SCL_W'(-32768);

  logic signed [15:0]      hist [TAPS];
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] sum_next;
  logic                    s1_valid;

  logic signed [EXT_W-1:0] sum_ext;
  logic signed [EXT_W-1:0] avg;
  logic signed [SCL_W-1:0] scaled;
  logic signed [15:0]      sat;

  // The running sum adds the newcomer and removes the sample that is about to
  // fall off the end of the window. The history starts at zero, so the first
  // outputs are partial averages.
  assign sum_next = sum_q + SUM_W'(in_data) - SUM_W'(hist[TAPS-1]);

  // Stage 1: history and running sum, advanced only on valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the history array is reset explicitly because it is part of the
      // running-sum state. A stale sample left in it would corrupt the sum
      // forever after. This costs reset fan-out, and here that cost is required.
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
      sum_q    <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        hist[0] <= in_data;
        for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
        sum_q <= sum_next;
      end
    end
  end

  // Stage 2 datapath: average, gain, saturate.
  always_comb begin
    // NOTE: every variable in this block is assigned on all paths (defaults
    // first, then overrides), so synthesis cannot infer a latch.
    sum_ext = EXT_W'(sum_q);
`ifdef OVERLAY_ROUND_EN
    // Round half-up: add half an LSB of the divided result before shifting.
    // For a one-tap window the bias is zero, so the rounding step has no effect.
    sum_ext = sum_ext + EXT_W'(TAPS / 2);
`endif
    avg    = sum_ext >>> LOG2_TAPS;
    scaled = SCL_W'(avg) <<< GAIN_SHIFT;
    sat    = scaled[15:0];
    if (scaled > SAT_MAX) begin
      sat = 16'sh7fff;
    end else if (scaled < SAT_MIN) begin
      sat = 16'sh8000;
    end
  end

  // Stage 2 register: the data holds its last value between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) out_data <= sat;
    end
  end

endmodule

module overlay_top #(
  parameter int LOG2_TAPS  = 2,
  parameter int GAIN_SHIFT = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic signed [15:0] i_I0_data,
  input  logic signed [15:0] i_Q0_data,
  input  logic signed [15:0] i_I1_data,
  input  logic signed [15:0] i_Q1_data,
  input  logic               i_I0_valid,
  input  logic               i_Q0_valid,
  input  logic               i_I1_valid,
  input  logic               i_Q1_valid,
  output logic signed [15:0] o_I0_data,
  output logic signed [15:0] o_Q0_data,
  output logic signed [15:0] o_I1_data,
  output logic signed [15:0] o_Q1_data,
  output logic               o_I0_valid,
  output logic               o_Q0_valid,
  output logic               o_I1_valid,
  output logic               o_Q1_valid
);

  // The four lanes are identical and do not share any state.
  overlay_lane #(.LOG2_TAPS(LOG2_TAPS), .GAIN_SHIFT(GAIN_SHIFT)) u_i0 (
    .clk(i_clk), .rst(i_rst),
    .in_data(i_I0_data), .in_valid(i_I0_valid),
    .out_data(o_I0_data), .out_valid(o_I0_valid)
  );

  overlay_lane #(.LOG2_TAPS(LOG2_TAPS), .GAIN_SHIFT(GAIN_SHIFT)) u_q0 (
    .clk(i_clk), .rst(i_rst),
    .in_data(i_Q0_data), .in_valid(i_Q0_valid),
    .out_data(o_Q0_data), .out_valid(o_Q0_valid)
  );

  overlay_lane #(.LOG2_TAPS(LOG2_TAPS), .GAIN_SHIFT(GAIN_SHIFT)) u_i1 (
    .clk(i_clk), .rst(i_rst),
    .in_data(i_I1_data), .in_valid(i_I1_valid),
    .out_data(o_I1_data), .out_valid(o_I1_valid)
  );

  overlay_lane #(.LOG2_TAPS(LOG2_TAPS), .GAIN_SHIFT(GAIN_SHIFT)) u_q1 (
    .clk(i_clk), .rst(i_rst),
    .in_data(i_Q1_data), .in_valid(i_Q1_valid),
    .out_data(o_Q1_data), .out_valid(o_Q1_valid)
  );

endmodule

// File: tb/tb_overlay_top.sv
// -----------------------------------------------------------------------------
// tb_overlay_top
//   This bench drives two overlay_top instances from the same stimulus. Both
//   use a four-tap window. One has unity gain and the other has a gain shift
//   of 4. The reference model keeps the last four accepted samples of each
//   lane in a queue. It computes the expected output as floor(sum / 4) (or
//   floor((sum + 2) / 4) when rounding is built in), then multiplies by the
//   gain and clamps the result. Outputs are compared 1 time unit after every
//   rising edge.
// -----------------------------------------------------------------------------

module tb_overlay_top;

  localparam int L    = 2;
  localparam int TAPS = 4;
  localparam int GAIN [2] = '{0, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [15:0] in_data  [4];
  logic               in_valid [4];
  logic        [15:0] out_data  [2][4];
  logic               out_valid [2][4];

  int checks = 0;
  int errors = 0;
  string phase = "init";

  // Reference model state.
  int hist_q [4][$];
  int exp_data_now  [2][4];
  int exp_data_next [2][4];
  bit exp_valid_now  [2][4];
  bit exp_valid_next [2][4];

  overlay_top #(.LOG2_TAPS(L), .GAIN_SHIFT(GAIN[0])) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_I0_data(in_data[0]), .i_Q0_data(in_data[1]),
    .i_I1_data(in_data[2]), .i_Q1_data(in_data[3]),
    .i_I0_valid(in_valid[0]), .i_Q0_valid(in_valid[1]),
    .i_I1_valid(in_valid[2]), .i_Q1_valid(in_valid[3]),
    .o_I0_data(out_data[0][0]), .o_Q0_data(out_data[0][1]),
    .o_I1_data(out_data[0][2]), .o_Q1_data(out_data[0][3]),
    .o_I0_valid(out_valid[0][0]), .o_Q0_valid(out_valid[0][1]),
    .o_I1_valid(out_valid[0][2]), .o_Q1_valid(out_valid[0][3])
  );

  overlay_top #(.LOG2_TAPS(L), .GAIN_SHIFT(GAIN[1])) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_I0_data(in_data[0]), .i_Q0_data(in_data[1]),
    .i_I1_data(in_data[2]), .i_Q1_data(in_data[3]),
    .i_I0_valid(in_valid[0]), .i_Q0_valid(in_valid[1]),
    .i_I1_valid(in_valid[2]), .i_Q1_valid(in_valid[3]),
    .o_I0_data(out_data[1][0]), .o_Q0_data(out_data[1][1]),
    .o_I1_data(out_data[1][2]), .o_Q1_data(out_data[1][3]),
    .o_I0_valid(out_valid[1][0]), .o_Q0_valid(out_valid[1][1]),
    .o_I1_valid(out_valid[1][2]), .o_Q1_valid(out_valid[1][3])
  );

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int floor_div(int a, int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int model_out(int lane, int gain);
    int s;
    int v;
    s = 0;
    for (int k = 0; k < hist_q[lane].size(); k++) s += hist_q[lane][k];
`ifdef OVERLAY_ROUND_EN
    s += TAPS / 2;
`endif
    v = floor_div(s, TAPS) * (1 << gain);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // Advance the model by one rising edge, using the inputs presented to it.
  task automatic model_edge();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 4; l++) begin
        exp_data_now[d][l]  = exp_data_next[d][l];
        exp_valid_now[d][l] = exp_valid_next[d][l];
      end
    for (int l = 0; l < 4; l++) begin
      if (rst) begin
        hist_q[l].delete();
        for (int k = 0; k < TAPS; k++) hist_q[l].push_back(0);
        for (int d = 0; d < 2; d++) begin
          exp_data_now[d][l]   = 0;
          exp_valid_now[d][l]  = 1'b0;
          exp_data_next[d][l]  = 0;
          exp_valid_next[d][l] = 1'b0;
        end
      end else if (in_valid[l]) begin
        hist_q[l].push_front(int'(in_data[l]));
        void'(hist_q[l].pop_back());
        for (int d = 0; d < 2; d++) begin
          exp_data_next[d][l]  = model_out(l, GAIN[d]);
          exp_valid_next[d][l] = 1'b1;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          exp_data_next[d][l]  = exp_data_now[d][l];
          exp_valid_next[d][l] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 4; l++) begin
        check($sformatf("%s_d%0d_l%0d_valid", phase, d, l),
              16'(out_valid[d][l]), 16'(exp_valid_now[d][l]));
        check($sformatf("%s_d%0d_l%0d_data", phase, d, l),
              out_data[d][l], 16'(exp_data_now[d][l]));
      end
  endtask

  task automatic set_idle();
    for (int l = 0; l < 4; l++) begin
      in_valid[l] = 1'b0;
      in_data[l]  = 16'($urandom);
    end
  endtask

  task automatic set_all(int v);
    for (int l = 0; l < 4; l++) begin
      in_valid[l] = 1'b1;
      in_data[l]  = 16'(v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset for three cycles with the valids toggling.
    phase = "reset";
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 4; l++) begin
        in_valid[l] = 1'(c + l);
        in_data[l]  = 16'($urandom);
      end
      tick();
      for (int l = 0; l < 4; l++) check("reset_hold_data_zero", out_data[0][l], 16'd0);
    end
    rst = 1'b0;

    // Single impulse on I0 right after reset.
    phase = "impulse";
    set_idle();
    in_valid[0] = 1'b1;
    in_data[0]  = 16'sd400;
    tick();
    set_idle();
    tick();
    check("impulse_I0_valid", 16'(out_valid[0][0]), 16'd1);
    check("impulse_I0_data", out_data[0][0], 16'd100);
    tick();
    check("impulse_I0_valid_one_cycle", 16'(out_valid[0][0]), 16'd0);

    // Fill ramp on all lanes.
    phase = "ramp";
    do_reset();
    set_all(1000);
    tick();
    set_all(1000);
    tick();
    check("ramp_out1", out_data[0][2], 16'd250);
    set_all(1000);
    tick();
    check("ramp_out2", out_data[0][1], 16'd500);
    set_all(1000);
    tick();
    check("ramp_out3", out_data[0][3], 16'd750);
    set_all(0);
    tick();
    check("ramp_out4", out_data[0][0], 16'd1000);
    check("gain_1000_unsat", out_data[1][0], 16'd16000);
    set_idle();
    tick();
    check("ramp_zero_in", out_data[0][0], 16'd750);
    tick();
    check("ramp_hold", out_data[0][0], 16'd750);

    // Saturation with gain shift 4.
    phase = "sat";
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_all(4000);
      tick();
    end
    set_all(-4000);
    tick();
    check("sat_pos_unity", out_data[0][1], 16'd4000);
    check("sat_pos_gain", out_data[1][1], 16'h7fff);
    for (int c = 0; c < 3; c++) begin
      set_all(-4000);
      tick();
    end
    set_idle();
    tick();
    check("sat_neg_unity", out_data[0][2], 16'(-4000));
    check("sat_neg_gain", out_data[1][2], 16'h8000);

    // Only Q1 is active, with 5-cycle gaps between samples.
    phase = "gaps";
    for (int s = 0; s < 6; s++) begin
      set_idle();
      in_valid[3] = 1'b1;
      in_data[3]  = 16'($urandom_range(0, 20000)) - 16'd10000;
      tick();
      set_idle();
      for (int g = 0; g < 5; g++) tick();
    end

    // Rounding corner cases.
    phase = "round";
    do_reset();
    set_idle();
    in_valid[0] = 1'b1;
    in_data[0]  = -16'sd1;
    tick();
    set_idle();
    tick();
`ifdef OVERLAY_ROUND_EN
    check("round_minus1", out_data[0][0], 16'd0);
`else
    check("round_minus1", out_data[0][0], 16'hffff);
`endif
    do_reset();
    set_idle();
    in_valid[0] = 1'b1;
    in_data[0]  = 16'sd2;
    tick();
    set_idle();
    tick();
`ifdef OVERLAY_ROUND_EN
    check("round_two", out_data[0][0], 16'd1);
`else
    check("round_two", out_data[0][0], 16'd0);
`endif

    // Randomized traffic, with occasional resets in the middle of the stream.
    phase = "random";
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int l = 0; l < 4; l++) begin
        in_valid[l] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) in_data[l] = 16'($urandom);
        else in_data[l] = 16'($urandom_range(0, 8000)) - 16'd4000;
      end
      tick();
    end
    rst = 1'b0;
    set_idle();
    for (int c = 0; c < 3; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
